// File: rtl/truth_table_scanner_if.sv
// Bundle of controller-facing and function-block-facing signals for the
// truth-table scanner. The scanner uses the slave modport; the controller
// (top level or bench) uses the master modport.
interface truth_table_scanner_if #(
    parameter int N_IN = 3
);
    localparam int VN = 2 ** N_IN;

    logic            start;
    logic [VN-1:0]   expected;
    logic            f_in;
    logic [N_IN-1:0] xyz;
    logic            busy;
    logic            done;
    logic [VN-1:0]   table_out;
    logic [N_IN:0]   minterm_count;
    logic            pass;
    logic            mismatch_valid;
    logic [N_IN-1:0] mismatch_idx;

    modport master (
        output start, expected, f_in,
        input  xyz, busy, done, table_out, minterm_count,
               pass, mismatch_valid, mismatch_idx
    );

    modport slave (
        input  start, expected, f_in,
        output xyz, busy, done, table_out, minterm_count,
               pass, mismatch_valid, mismatch_idx
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Exhaustive sequencer for an external combinational function block.
// Walks xyz through every input vector, lets each settle for SETTLE cycles,
// samples f_in, builds the truth table, counts minterms and compares the
// final table against the expected mask.
module truth_table_scanner #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input logic                  clk,
    input logic                  reset,
    truth_table_scanner_if.slave bus
);
    localparam int VN = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'((SETTLE > 0) ? (SETTLE - 1) : 0);
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(VN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state_r;
    logic [N_IN-1:0] idx_r;
    logic [CW-1:0]   cnt_r;
    logic [N_IN-1:0] xyz_r;
    logic            busy_r;
    logic            done_r;
    logic [VN-1:0]   table_r;
    logic [N_IN:0]   count_r;
    logic            pass_r;
    logic            mv_r;
    logic [N_IN-1:0] mi_r;

    logic [VN-1:0]   table_next_s;
    logic [VN-1:0]   diff_s;

    // Lowest set bit position of a difference vector; 0 when no bit is set.
    function automatic logic [N_IN-1:0] lowest_set(input logic [VN-1:0] v);
        logic [N_IN-1:0] r;
        r = '0;
        for (int i = VN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = N_IN'(i);
            end
        end
        return r;
    endfunction

    // Table including the sample being taken this cycle, and its difference
    // from the expected mask (only meaningful on the final sample).
    always_comb begin
        table_next_s        = table_r;
        table_next_s[idx_r] = bus.f_in;
        diff_s              = table_next_s ^ bus.expected;
    end

    // Scan sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
            xyz_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            table_r <= '0;
            count_r <= '0;
            pass_r  <= 1'b0;
            mv_r    <= 1'b0;
            mi_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    xyz_r  <= '0;
                    if (bus.start) begin
                        idx_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        table_r <= '0;
                        count_r <= '0;
                        pass_r  <= 1'b0;
                        mv_r    <= 1'b0;
                        mi_r    <= '0;
                        state_r <= (SETTLE > 0) ? WAIT : SAMPLE;
                    end
                end
                WAIT: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_r   <= '0;
                        state_r <= SAMPLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                SAMPLE: begin
                    table_r <= table_next_s;
                    count_r <= count_r + (N_IN + 1)'(bus.f_in);
                    if (idx_r == LAST_IDX) begin
                        pass_r  <= (diff_s == '0);
                        mv_r    <= (diff_s != '0);
                        mi_r    <= lowest_set(diff_s);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= FINISH;
                    end else begin
                        idx_r   <= idx_r + N_IN'(1);
                        xyz_r   <= idx_r + N_IN'(1);
                        state_r <= (SETTLE > 0) ? WAIT : SAMPLE;
                    end
                end
                FINISH: begin
                    done_r  <= 1'b0;
                    xyz_r   <= '0;
                    idx_r   <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    xyz_r   <= '0;
                    idx_r   <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.xyz            = xyz_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.table_out      = table_r;
    assign bus.minterm_count  = count_r;
    assign bus.pass           = pass_r;
    assign bus.mismatch_valid = mv_r;
    assign bus.mismatch_idx   = mi_r;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: one scanner with SETTLE=1 driving f = ~(x & ~y) & z,
// and one with SETTLE=0 fed a bench-controlled constant f_in.
module tb_truth_table_scanner;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   dones;

    truth_table_scanner_if #(.N_IN(3)) bus_a ();
    truth_table_scanner_if #(.N_IN(3)) bus_b ();

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Function block under test: f = ~(x & ~y) & z
    assign bus_a.f_in = ~(bus_a.xyz[2] & ~bus_a.xyz[1]) & bus_a.xyz[0];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full scan on the SETTLE=1 instance; optionally re-pulses start after edge k+restart_j.
    task automatic scan_a(input logic [7:0] mask, input logic [7:0] exp_table,
                          input logic [3:0] exp_count, input logic exp_pass,
                          input logic exp_mv, input logic [2:0] exp_midx,
                          input int restart_j);
        int nd;
        nd = 0;
        bus_a.expected = mask;
        bus_a.start    = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        check("a_busy_at_start", bus_a.busy, 1);
        check("a_xyz_at_start", bus_a.xyz, 0);
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk); #1;
            if (bus_a.done) nd++;
            if (j < 16) begin
                check("a_xyz_step", bus_a.xyz, j / 2);
                check("a_busy_mid", bus_a.busy, 1);
            end else begin
                check("a_done_at_16", bus_a.done, 1);
                check("a_busy_at_done", bus_a.busy, 0);
                check("a_table", bus_a.table_out, exp_table);
                check("a_count", bus_a.minterm_count, exp_count);
                check("a_pass", bus_a.pass, exp_pass);
                check("a_mismatch_valid", bus_a.mismatch_valid, exp_mv);
                check("a_mismatch_idx", bus_a.mismatch_idx, exp_midx);
            end
            bus_a.start = (j == restart_j) ? 1'b1 : 1'b0;
        end
        bus_a.start = 1'b0;
        @(posedge clk); #1;
        if (bus_a.done) nd++;
        check("a_done_one_cycle", bus_a.done, 0);
        check("a_xyz_idle", bus_a.xyz, 0);
        check("a_table_hold", bus_a.table_out, exp_table);
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (bus_a.done) nd++;
        end
        check("a_done_pulses", nd, 1);
        check("a_pass_hold", bus_a.pass, exp_pass);
    endtask

    // Full scan on the SETTLE=0 instance with constant f_in.
    task automatic scan_b(input logic fval, input logic [7:0] mask,
                          input logic [7:0] exp_table, input logic [3:0] exp_count);
        bus_b.f_in     = fval;
        bus_b.expected = mask;
        bus_b.start    = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        check("b_busy_at_start", bus_b.busy, 1);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j < 8) begin
                check("b_xyz_step", bus_b.xyz, j);
                check("b_done_early", bus_b.done, 0);
            end else begin
                check("b_done_at_8", bus_b.done, 1);
                check("b_table", bus_b.table_out, exp_table);
                check("b_count", bus_b.minterm_count, exp_count);
                check("b_pass", bus_b.pass, 1);
                check("b_mismatch_valid", bus_b.mismatch_valid, 0);
            end
        end
        @(posedge clk); #1;
        check("b_done_clear", bus_b.done, 0);
        check("b_busy_idle", bus_b.busy, 0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        clk            = 1'b0;
        reset          = 1'b1;
        bus_a.start    = 1'b0;
        bus_a.expected = 8'h00;
        bus_b.start    = 1'b0;
        bus_b.expected = 8'h00;
        bus_b.f_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: everything zero, no done for 40 cycles.
        check("rst_table", bus_a.table_out, 0);
        check("rst_count", bus_a.minterm_count, 0);
        check("rst_pass", bus_a.pass, 0);
        check("rst_mv", bus_a.mismatch_valid, 0);
        check("rst_midx", bus_a.mismatch_idx, 0);
        dones = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (bus_a.done || bus_a.busy || bus_b.done || bus_b.busy || bus_a.xyz != 3'd0) dones++;
        end
        check("rst_idle_40", dones, 0);

        // Matching expected mask.
        scan_a(8'h8A, 8'h8A, 4'd3, 1'b1, 1'b0, 3'd0, -1);
        // Mismatch at index 5.
        scan_a(8'hAA, 8'h8A, 4'd3, 1'b0, 1'b1, 3'd5, -1);
        // Constant functions on the zero-settle instance.
        scan_b(1'b1, 8'hFF, 8'hFF, 4'd8);
        scan_b(1'b0, 8'h00, 8'h00, 4'd0);
        // Start pulsed while xyz=3 must be ignored.
        scan_a(8'h8A, 8'h8A, 4'd3, 1'b1, 1'b0, 3'd0, 6);

        // Reset in the middle of a scan at xyz=4.
        bus_a.expected = 8'h8A;
        bus_a.start    = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_xyz_before_reset", bus_a.xyz, 4);
        check("mid_table_before_reset", bus_a.table_out, 8'h0A);
        reset = 1'b1;
        #1;
        check("mid_reset_busy", bus_a.busy, 0);
        check("mid_reset_xyz", bus_a.xyz, 0);
        check("mid_reset_table", bus_a.table_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (bus_a.done || bus_a.busy) dones++;
        end
        check("mid_reset_no_done", dones, 0);
        scan_a(8'h8A, 8'h8A, 4'd3, 1'b1, 1'b0, 3'd0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequencer that exhaustively drives the select inputs of an external combinational boolean function block (e.g. a 3-input x/y/z SoP/PoS function).
- Captures the function output for every input combination into a truth-table vector, counts minterms and compares the vector against an expected mask.
- Replaces hand-written stimulus sweeps; sits beside the function block under test, driven by a top-level or bench controller.

Parameters:
- N_IN, 3, number of function inputs; vector count is 2^N_IN.
- SETTLE, 1, wait cycles between driving an input vector and sampling f_in (0 allowed).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin scan; sampled only in IDLE
- expected  input  2^N_IN  expected truth table; bit i = f(i)
- f_in  input  1  output of external function block
- xyz  output  N_IN  input vector to function block; MSB = x, LSB = z
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse, results valid
- table_out  output  2^N_IN  captured truth table; bit i = f(xyz=i)
- minterm_count  output  N_IN+1  number of 1s in table_out
- pass  output  1  table_out == expected
- mismatch_valid  output  1  at least one bit differs
- mismatch_idx  output  N_IN  lowest index where table_out differs from expected

Behaviour:
- Reset (async, immediate): state = IDLE; all outputs 0; internal index and settle counter 0. Reset mid-scan aborts and no done is produced.
- States: IDLE, WAIT, SAMPLE, FINISH.
- IDLE, start=1:
  - idx = 0, xyz = 0.
  - Clear table_out, minterm_count, pass and mismatch outputs.
  - busy = 1.
  - Next state is WAIT if SETTLE>0, otherwise SAMPLE.
- WAIT: hold xyz = idx for SETTLE cycles, then go to SAMPLE.
- SAMPLE: at the next edge:
  - table_out[idx] = f_in; minterm_count += f_in.
  - If idx == 2^N_IN-1, go to FINISH.
  - Otherwise idx++, xyz = idx+1, and go to WAIT (or SAMPLE if SETTLE=0).
- Each vector occupies exactly SETTLE+1 cycles. xyz changes only when entering a new vector and is stable throughout its WAIT/SAMPLE window.
- FINISH:
  - done = 1 and busy = 0 for exactly one cycle; next state is IDLE.
  - If start was accepted at edge k, done is high in the cycle following edge k + 2^N_IN*(SETTLE+1).
- Results (table_out, minterm_count, pass, mismatch_valid, mismatch_idx) are registered at the edge entering FINISH and include the final sample. They hold until the next accepted start or reset.
- pass = 1 iff every bit matches; then mismatch_valid = 0 and mismatch_idx = 0.
- expected is sampled at the edge entering FINISH; it must be stable during the scan.
- start while busy or in FINISH is ignored (no restart, no queuing). start held continuously restarts on the first IDLE cycle after FINISH.
- minterm_count width N_IN+1 holds 2^N_IN without overflow.
- xyz returns to 0 in IDLE after FINISH.

Test Plan:
- Reset, then release with start=0 -> all outputs 0, busy=0, no done for 40 cycles.
- f_in driven by ~(x & ~y) & z, expected=8'h8A, SETTLE=1, start at edge k:
  - busy high from k.
  - xyz steps 0..7, each value held for 2 cycles.
  - done pulses one cycle after edge k+16.
  - table_out=8'h8A, minterm_count=3, pass=1, mismatch_valid=0.
- Same function, expected=8'hAA -> pass=0, mismatch_valid=1, mismatch_idx=5, table_out=8'h8A.
- Constant f_in=1, expected=8'hFF, SETTLE=0 -> done after 8 cycles, minterm_count=8 (4'b1000), pass=1. Repeat with f_in=0, expected=8'h00 -> minterm_count=0, pass=1.
- Pulse start again at xyz=3 during a scan -> ignored: the scan completes on the original schedule and exactly one done pulse is produced.
- Assert reset while xyz=4 -> busy, xyz and table_out go to 0 immediately, no done. A new start afterwards produces a correct full scan (8'h8A).
